// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg
// Shared definitions for the serial boot loader: loader FSM state encoding,
// the number of stream bytes that make one instruction word, and a small
// helper that recognises the final byte of a word.
package boot_loader_pkg;

  // Loader FSM states, in stream order.
  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // True when the byte counter points at the last byte of a word.
  function automatic logic is_last_byte(input logic [1:0] cnt);
    return cnt == 2'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// byte_packer
// Assembles consecutive stream bytes into 32-bit words, MSB first.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   en          a payload byte is being consumed this cycle
//   byte_in     the payload byte
//   word        word as it will look once byte_in is shifted in
//   word_done   en is set and byte_in completes the current word
module byte_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  cnt;
  logic [31:0] shreg;

  // The completed word is presented combinationally so the parent can
  // register it on the same edge that consumes the 4th byte.
  assign word      = {shreg[23:0], byte_in};
  assign word_done = en && is_last_byte(cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 2'd0;
      shreg <= 32'd0;
    end else if (en) begin
      // After four shifts the older bytes have fully left the register,
      // so no explicit clear is needed between words.
      shreg <= word;
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader
// Receives a program image over a valid/ready byte stream, writes it into
// instruction memory one 32-bit word at a time and releases the processor
// reset once the whole image has arrived with a matching XOR checksum.
// Stream: LEN_HI, LEN_LO (word count N), 4*N payload bytes MSB first,
// then one checksum byte (XOR of the payload bytes).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_data        byte stream from the host
//   in_ready                 loader can take a byte this cycle
//   im_we, im_addr, im_wdata instruction-memory write port
//   cpu_rst                  processor reset, released on success
//   done, error              sticky completion / failure flags
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  logic [15:0] len;
  logic [15:0] widx;
  logic [7:0]  csum;

  logic        accept;
  logic        pk_en;
  logic        pk_done;
  logic [31:0] pk_word;
  logic [15:0] len_next;

  // Ready is a decode of the state; it is also forced low while reset is
  // held so nothing is consumed during the reset cycle.
  assign in_ready = !rst && (state inside {LEN_HI, LEN_LO, DATA, CHECK});
  assign accept   = in_valid && in_ready;
  assign pk_en    = accept && (state == DATA);
  assign len_next = {len[15:8], in_data};

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .en        (pk_en),
    .byte_in   (in_data),
    .word      (pk_word),
    .word_done (pk_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LEN_HI;
      len      <= 16'd0;
      widx     <= 16'd0;
      csum     <= 8'd0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= 32'd0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (accept) begin
        case (state)
          LEN_HI: begin
            len[15:8] <= in_data;
            state     <= LEN_LO;
          end
          LEN_LO: begin
            len[7:0] <= in_data;
            if ({1'b0, len_next} > DEPTH_W) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum <= csum ^ in_data;
            if (pk_done) begin
              // Address and data only change with a write, so they keep
              // their last values while im_we is low.
              im_we    <= 1'b1;
              im_addr  <= widx[ADDR_W-1:0];
              im_wdata <= pk_word;
              widx     <= widx + 16'd1;
              if (widx == len - 16'd1) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (in_data == csum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
          default: begin
            // DONE and ERROR hold until reset; in_ready is low there.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every memory write strobe is logged in order.
  int          wcnt = 0;
  logic [31:0] wa [0:2047];
  logic [31:0] wd [0:2047];
  always @(negedge clk) begin
    if (im_we === 1'b1 && wcnt < 2048) begin
      wa[wcnt] = 32'(im_addr);
      wd[wcnt] = im_wdata;
      wcnt++;
    end
  end

  logic [7:0]  stim [$];
  logic [31:0] exp_a [$];
  logic [31:0] exp_d [$];
  bit          exp_done;
  bit          exp_err;
  int          nvec = 0;
  int          nerr = 0;
  int          base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: interpret the stream with the format rules directly.
  task automatic model();
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_a.delete();
    exp_d.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'(stim[0]) * 256 + int'(stim[1]);
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++) begin
        w = (w << 8) | 32'(stim[2 + 4*i + k]);
        x = x ^ stim[2 + 4*i + k];
      end
      exp_a.push_back(32'(i));
      exp_d.push_back(w);
    end
    if (stim[2 + 4*n] == x) exp_done = 1'b1;
    else                    exp_err  = 1'b1;
  endtask

  task automatic build_rand(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    if (n > DEPTH) begin
      for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
      return;
    end
    x = 8'd0;
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ 8'($urandom_range(255, 1));
    stim.push_back(x);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_in_rst"}, 32'(in_ready), 32'd0);
    chk({tag, "_we_rst"},     32'(im_we),    32'd0);
    chk({tag, "_addr_rst"},   32'(im_addr),  32'd0);
    chk({tag, "_wdata_rst"},  im_wdata,      32'd0);
    chk({tag, "_cpurst_rst"}, 32'(cpu_rst),  32'd1);
    chk({tag, "_done_rst"},   32'(done),     32'd0);
    chk({tag, "_err_rst"},    32'(error),    32'd0);
    rst = 1'b0;
    #1;
    chk({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
    base = wcnt;
  endtask

  // Send up to `limit` bytes of stim; in_valid is asserted with probability
  // vpct percent. Stops early if the loader stops accepting.
  task automatic send(input int limit, input int vpct, input string tag);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < limit && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (!in_ready) begin
        in_valid = 1'b0;
        break;
      end
      in_data  = stim[i];
      in_valid = ($urandom_range(99, 0) < vpct);
      if (in_valid) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    nvec++;
    assert (guard < 20000) else begin
      nerr++;
      $error("FAIL %s_timeout observed=%0d expected=<20000", tag, guard);
    end
  endtask

  // Outcome and writes are checked one cycle after the final byte.
  task automatic check_result(input string tag);
    int got;
    chk({tag, "_done"},   32'(done),     32'(exp_done));
    chk({tag, "_error"},  32'(error),    32'(exp_err));
    chk({tag, "_cpurst"}, 32'(cpu_rst),  32'(!exp_done));
    chk({tag, "_rdy"},    32'(in_ready), 32'(!(exp_done || exp_err)));
    got = wcnt - base;
    chk({tag, "_nwr"}, 32'(got), 32'(exp_a.size()));
    for (int k = 0; k < exp_a.size() && k < got; k++) begin
      chk({tag, "_addr"}, wa[base + k], exp_a[k]);
      chk({tag, "_data"}, wd[base + k], exp_d[k]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;

    // Single word image.
    do_reset("r35");
    stim = {8'h00, 8'h01, 8'h8C, 8'h0A, 8'h00, 8'h00, 8'h86};
    model();
    send(stim.size(), 100, "r35");
    check_result("r35");
    if (wcnt > base) chk("r35_lit", wd[base], 32'h8C0A0000);

    // Bytes offered after DONE must be ignored.
    base = wcnt;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_done_nwr", 32'(wcnt - base), 32'd0);
    chk("post_done_flag", 32'(done), 32'd1);
    chk("post_done_rdy", 32'(in_ready), 32'd0);

    // Two words; checksum is the XOR of the eight payload bytes (0x55).
    do_reset("r36");
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    model();
    send(stim.size(), 100, "r36");
    check_result("r36");

    // Same image, wrong checksum.
    do_reset("r37");
    stim[10] = 8'h00;
    model();
    send(stim.size(), 100, "r37");
    check_result("r37");

    // Length one past capacity.
    do_reset("r38");
    stim = {8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    model();
    send(stim.size(), 100, "r38");
    check_result("r38");

    // Gapped valid on the two-word image.
    for (int r = 0; r < 3; r++) begin
      do_reset("r39");
      stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
      model();
      send(stim.size(), 40, "r39");
      check_result("r39");
    end

    // Abort after the 3rd payload byte, then reload.
    do_reset("r40a");
    stim = {8'h00, 8'h01, 8'h8C, 8'h0A, 8'h00, 8'h00, 8'h86};
    send(5, 100, "r40a");
    repeat (2) @(negedge clk);
    chk("r40_abort_nwr", 32'(wcnt - base), 32'd0);
    do_reset("r40b");
    model();
    send(stim.size(), 100, "r40b");
    check_result("r40");

    // Full-capacity image.
    do_reset("full");
    build_rand(DEPTH, 1'b0);
    model();
    send(stim.size(), 100, "full");
    check_result("full");

    // Randomized images: size, corruption and valid density all vary.
    for (int r = 0; r < 12; r++) begin
      int n;
      do_reset("rnd");
      if (r % 5 == 4) n = DEPTH + $urandom_range(300, 1);
      else            n = $urandom_range(6, 0);
      build_rand(n, ($urandom_range(2, 0) == 0));
      model();
      send(stim.size(), $urandom_range(100, 30), "rnd");
      check_result("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
